// File: rtl/lcd_bus_if.sv
// Host-side 8080-style 18-bit parallel LCD bus; the host (SoC LCD interface)
// is the master, the panel responder is the slave.
interface lcd_bus_if;
    logic [17:0] lcd_db_in;
    logic [17:0] lcd_db_out;
    logic        lcd_db_oe;
    logic        lcd_rs;
    logic        lcd_wr;
    logic        lcd_rd;
    logic        lcd_cs;

    modport master (
        output lcd_db_in, lcd_rs, lcd_wr, lcd_rd, lcd_cs,
        input  lcd_db_out, lcd_db_oe
    );

    modport slave (
        input  lcd_db_in, lcd_rs, lcd_wr, lcd_rd, lcd_cs,
        output lcd_db_out, lcd_db_oe
    );
endinterface

// File: rtl/lcd_bus_responder.sv
// Panel-side responder for the 8080-style LCD bus: command/window decode,
// pixel FIFO towards a framebuffer writer, host reads and FMARK generation.
module lcd_bus_responder #(
    parameter int          WIDTH        = 480,
    parameter int          HEIGHT       = 320,
    parameter int          ADDR_W       = 18,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          FRAME_CYCLES = 200000,
    parameter int          FMARK_WIDTH  = 16,
    parameter logic [23:0] ID_VALUE     = 24'h009341
) (
    input  logic              clk,
    input  logic              nrst,
    lcd_bus_if.slave          bus,
    input  logic              lcd_rst,
    output logic              lcd_fmark,
    output logic              lcd_id,
    output logic              px_valid,
    input  logic              px_ready,
    output logic [ADDR_W-1:0] px_addr,
    output logic [17:0]       px_data,
    output logic              overflow
);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FRAME_CYCLES);
    localparam int ENT_W = ADDR_W + 18;

    // Two-flop synchronizers plus one history flop for edge detection.
    // Strobes idle high so a reset release never looks like an edge.
    logic [1:0]  wr_sy, rd_sy, cs_sy, rs_sy, rst_sy;
    logic [17:0] db_sy1, db_sy2;
    logic        wr_q, rd_q, cs_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_sy  <= 2'b11;
            rd_sy  <= 2'b11;
            cs_sy  <= 2'b11;
            rs_sy  <= 2'b00;
            rst_sy <= 2'b00;
            db_sy1 <= '0;
            db_sy2 <= '0;
            wr_q   <= 1'b1;
            rd_q   <= 1'b1;
            cs_q   <= 1'b1;
        end else begin
            wr_sy  <= {wr_sy[0], bus.lcd_wr};
            rd_sy  <= {rd_sy[0], bus.lcd_rd};
            cs_sy  <= {cs_sy[0], bus.lcd_cs};
            rs_sy  <= {rs_sy[0], bus.lcd_rs};
            rst_sy <= {rst_sy[0], lcd_rst};
            db_sy1 <= bus.lcd_db_in;
            db_sy2 <= db_sy1;
            wr_q   <= wr_sy[1];
            rd_q   <= rd_sy[1];
            cs_q   <= cs_sy[1];
        end
    end

    logic        cs_s, rs_s;
    logic [17:0] db_s;
    logic        wr_ev, rd_fall, rd_rise, cs_rise;
    assign cs_s    = cs_sy[1];
    assign rs_s    = rs_sy[1];
    assign db_s    = db_sy2;
    assign wr_ev   = wr_sy[1] && !wr_q && !cs_s;
    assign rd_fall = !rd_sy[1] && rd_q && !cs_s;
    assign rd_rise = rd_sy[1] && !rd_q;
    assign cs_rise = cs_s && !cs_q;

    logic [7:0]       cmd;
    logic [2:0]       param_idx;
    logic [15:0]      p_start;
    logic [7:0]       p_end_hi;
    logic [COL_W-1:0] sc, ec, col;
    logic [ROW_W-1:0] sp, ep, row;
    logic             te_en;
    logic [PTR_W:0]   wp, rp;
    logic [17:0]      db_out_r;
    logic             oe_r;
    logic [CNT_W-1:0] fm_cnt;
    logic [ENT_W-1:0] mem [FIFO_DEPTH];

    // SWRESET acts exactly like the pin/system reset for one clock.
    logic clr;
    assign clr = !nrst || !rst_sy[1] || (wr_ev && !rs_s && db_s[7:0] == 8'h01);

    function automatic logic [15:0] clamp16(input logic [15:0] v, input int modulus);
        if ({16'd0, v} >= 32'(modulus)) return 16'(modulus - 1);
        return v;
    endfunction

    // Window bounds as they would be committed by the final (4th) parameter.
    logic [15:0] win_s, win_e;
    always_comb begin
        win_s = clamp16(p_start, (cmd == 8'h2A) ? WIDTH : HEIGHT);
        win_e = clamp16({p_end_hi, db_s[7:0]}, (cmd == 8'h2A) ? WIDTH : HEIGHT);
        if (win_e < win_s) win_e = win_s;
    end

    // px_* handshake: a pixel transfers on every clk where px_valid && px_ready;
    // px_valid never drops and px_addr/px_data never change while a pixel waits.
    logic              full, pix_cmd, push_req, push_ok, pop;
    logic [ADDR_W-1:0] pix_addr;
    assign full     = (wp[PTR_W] != rp[PTR_W]) && (wp[PTR_W-1:0] == rp[PTR_W-1:0]);
    assign px_valid = (wp != rp);
    assign pop      = px_valid && px_ready;
    assign pix_cmd  = (cmd == 8'h2C) || (cmd == 8'h3C);
    assign push_req = wr_ev && rs_s && pix_cmd;
    assign push_ok  = push_req && (!full || pop) && !clr;
    assign pix_addr = ADDR_W'(row) * ADDR_W'(WIDTH) + ADDR_W'(col);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wp[PTR_W-1:0]] <= {pix_addr, db_s};
    end

    assign {px_addr, px_data} = px_valid ? mem[rp[PTR_W-1:0]] : '0;

    logic [17:0] rd_val;
    always_comb begin
        rd_val = '0;
        case (cmd)
            8'h04: begin
                case (param_idx)
                    3'd0:    rd_val[7:0] = ID_VALUE[23:16];
                    3'd1:    rd_val[7:0] = ID_VALUE[15:8];
                    3'd2:    rd_val[7:0] = ID_VALUE[7:0];
                    default: rd_val = '0;
                endcase
            end
            8'h0A:   rd_val[2:0] = {te_en, overflow, px_valid};
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cmd       <= 8'h00;
            param_idx <= '0;
            p_start   <= '0;
            p_end_hi  <= '0;
            sc        <= '0;
            ec        <= COL_W'(WIDTH - 1);
            sp        <= '0;
            ep        <= ROW_W'(HEIGHT - 1);
            col       <= '0;
            row       <= '0;
            te_en     <= 1'b0;
            wp        <= '0;
            rp        <= '0;
            overflow  <= 1'b0;
            db_out_r  <= '0;
            oe_r      <= 1'b0;
            fm_cnt    <= '0;
        end else begin
            fm_cnt <= (fm_cnt == CNT_W'(FRAME_CYCLES - 1)) ? '0 : fm_cnt + CNT_W'(1);
            if (pop)     rp <= rp + (PTR_W+1)'(1);
            if (push_ok) wp <= wp + (PTR_W+1)'(1);
            // Dropped pixels still advance the address counters below.
            if (push_req && !push_ok) overflow <= 1'b1;

            if (wr_ev && !rs_s) begin
                cmd       <= db_s[7:0];
                param_idx <= '0;
                case (db_s[7:0])
                    8'h2C: begin
                        col <= sc;
                        row <= sp;
                    end
                    8'h35:   te_en <= 1'b1;
                    8'h34:   te_en <= 1'b0;
                    default: ;
                endcase
            end else if (wr_ev) begin
                if (param_idx != 3'd4) param_idx <= param_idx + 3'd1;
                if (cmd == 8'h2A || cmd == 8'h2B) begin
                    case (param_idx)
                        3'd0: p_start[15:8] <= db_s[7:0];
                        3'd1: p_start[7:0]  <= db_s[7:0];
                        3'd2: p_end_hi      <= db_s[7:0];
                        3'd3: begin
                            if (cmd == 8'h2A) begin
                                sc <= COL_W'(win_s);
                                ec <= COL_W'(win_e);
                            end else begin
                                sp <= ROW_W'(win_s);
                                ep <= ROW_W'(win_e);
                            end
                        end
                        default: ;
                    endcase
                end
                if (pix_cmd) begin
                    if (col == ec) begin
                        col <= sc;
                        if (row == ep)                       row <= sp;
                        else if (row == ROW_W'(HEIGHT - 1))  row <= '0;
                        else                                 row <= row + ROW_W'(1);
                    end else if (col == COL_W'(WIDTH - 1)) begin
                        col <= '0;
                    end else begin
                        col <= col + COL_W'(1);
                    end
                end
            end

            if (rd_fall) begin
                oe_r     <= 1'b1;
                db_out_r <= rd_val;
            end
            if (rd_rise || cs_rise) begin
                oe_r     <= 1'b0;
                db_out_r <= '0;
            end
            if (rd_rise && !cs_s && param_idx != 3'd4) param_idx <= param_idx + 3'd1;
        end
    end

    assign bus.lcd_db_out = db_out_r;
    assign bus.lcd_db_oe  = oe_r;
    assign lcd_fmark      = te_en && (fm_cnt < CNT_W'(FMARK_WIDTH));
    assign lcd_id         = ID_VALUE[0];
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: host bus driver tasks, a window/FIFO model with
// a pixel queue, and one negedge compare process for pixels and FMARK.
module tb_lcd_bus_responder;
    localparam int WIDTH  = 480;
    localparam int HEIGHT = 320;
    localparam int ADDR_W = 18;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 200;
    localparam int FMW    = 16;

    logic              clk = 1'b0;
    logic              nrst, lcd_rst, px_ready;
    logic              lcd_fmark, lcd_id, px_valid, overflow;
    logic [ADDR_W-1:0] px_addr;
    logic [17:0]       px_data;

    lcd_bus_if bus ();

    lcd_bus_responder #(.FRAME_CYCLES(FRAME), .FMARK_WIDTH(FMW)) dut (
        .clk(clk), .nrst(nrst), .bus(bus), .lcd_rst(lcd_rst),
        .lcd_fmark(lcd_fmark), .lcd_id(lcd_id), .px_valid(px_valid),
        .px_ready(px_ready), .px_addr(px_addr), .px_data(px_data),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Behavioural model state
    logic [ADDR_W+17:0] exp_q[$];
    int addr_log[$];
    int data_log[$];
    int m_cmd, m_idx, m_sc, m_ec, m_sp, m_ep, m_col, m_row;
    int m_p[4];
    bit m_ovf;
    bit te_exp = 0, fm_check = 0, locked = 0, fm_prev = 0, px_check = 1;
    int t0, cyc = 0, n_pop = 0;

    task automatic model_reset();
        m_cmd = 0; m_idx = 0; m_col = 0; m_row = 0; m_ovf = 0;
        m_sc = 0; m_ec = WIDTH - 1; m_sp = 0; m_ep = HEIGHT - 1;
        exp_q.delete();
    endtask

    function automatic int clampv(input int v, input int m);
        return (v >= m) ? m - 1 : v;
    endfunction

    task automatic model_write(input bit rs, input logic [17:0] d);
        int s, e, md;
        if (!rs) begin
            m_cmd = int'(d[7:0]);
            m_idx = 0;
            if (m_cmd == 'h2C) begin m_col = m_sc; m_row = m_sp; end
        end else begin
            if ((m_cmd == 'h2A || m_cmd == 'h2B) && m_idx < 4) begin
                m_p[m_idx] = int'(d[7:0]);
                if (m_idx == 3) begin
                    md = (m_cmd == 'h2A) ? WIDTH : HEIGHT;
                    s = clampv(m_p[0] * 256 + m_p[1], md);
                    e = clampv(m_p[2] * 256 + m_p[3], md);
                    if (s > e) e = s;
                    if (m_cmd == 'h2A) begin m_sc = s; m_ec = e; end
                    else begin m_sp = s; m_ep = e; end
                end
            end
            if (m_cmd == 'h2C || m_cmd == 'h3C) begin
                if (exp_q.size() >= DEPTH) m_ovf = 1;
                else exp_q.push_back({ADDR_W'(m_row * WIDTH + m_col), d});
                if (m_col == m_ec) begin
                    m_col = m_sc;
                    m_row = (m_row == m_ep) ? m_sp : (m_row + 1) % HEIGHT;
                end else m_col = (m_col + 1) % WIDTH;
            end
            if (m_idx < 4) m_idx++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wr_bus(input bit rs, input logic [17:0] d);
        bus.lcd_rs = rs;
        bus.lcd_db_in = d;
        step(1);
        bus.lcd_wr = 1'b0;
        step(2 + $urandom_range(0, 1));
        bus.lcd_wr = 1'b1;
        if (bus.lcd_cs == 1'b0) model_write(rs, d);
        step(4 + $urandom_range(0, 3));
    endtask

    task automatic send_win(input logic [7:0] c, input int s, input int e);
        wr_bus(0, {10'd0, c});
        wr_bus(1, 18'((s >> 8) & 'hFF));
        wr_bus(1, 18'(s & 'hFF));
        wr_bus(1, 18'((e >> 8) & 'hFF));
        wr_bus(1, 18'(e & 'hFF));
    endtask

    task automatic rd_check(input string nm, input logic [17:0] exp);
        bus.lcd_rd = 1'b0;
        step(4);
        chk({nm, "_oe"}, 36'(bus.lcd_db_oe), 36'(1));
        chk(nm, 36'(bus.lcd_db_out), 36'(exp));
        bus.lcd_rd = 1'b1;
        step(4);
        chk({nm, "_oe_off"}, 36'(bus.lcd_db_oe), 36'(0));
        if (m_idx < 4) m_idx++;
    endtask

    task automatic set_te(input bit on);
        fm_check = 0;
        wr_bus(0, on ? 18'h35 : 18'h34);
        te_exp = on;
        locked = 0;
        fm_check = 1;
    endtask

    // Compare process: pixel stream against the queue, FMARK against its period.
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (px_check && px_valid) begin
            chk("px_pending", 36'(exp_q.size() != 0), 36'(1));
            if (exp_q.size() != 0) begin
                chk(px_ready ? "px_pop" : "px_head", {px_addr, px_data}, exp_q[0]);
                if (px_ready) begin
                    void'(exp_q.pop_front());
                    addr_log.push_back(int'(px_addr));
                    data_log.push_back(int'(px_data));
                    n_pop++;
                end
            end
        end
        if (fm_check) begin
            if (!te_exp) chk("fmark_off", 36'(lcd_fmark), 36'(0));
            else begin
                if (!locked && !lcd_fmark && fm_prev) begin
                    locked = 1;
                    t0 = cyc - FMW;
                end
                if (locked) chk("fmark", 36'(lcd_fmark), 36'(((cyc - t0) % FRAME) < FMW));
            end
        end
        fm_prev = lcd_fmark;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int exp2[5];
        int s, e, n, p0;
        exp2 = '{2410, 2411, 2890, 2891, 2410};
        nrst = 0; lcd_rst = 1; px_ready = 1;
        bus.lcd_wr = 1; bus.lcd_rd = 1; bus.lcd_cs = 1; bus.lcd_rs = 0; bus.lcd_db_in = '0;
        model_reset();
        step(4);
        nrst = 1;
        step(6);
        chk("rst_oe", 36'(bus.lcd_db_oe), 36'(0));
        chk("rst_db_out", 36'(bus.lcd_db_out), 36'(0));
        chk("rst_px_valid", 36'(px_valid), 36'(0));
        chk("rst_px_addr", 36'(px_addr), 36'(0));
        chk("rst_overflow", 36'(overflow), 36'(0));
        chk("rst_fmark", 36'(lcd_fmark), 36'(0));
        chk("lcd_id", 36'(lcd_id), 36'(1));
        fm_check = 1;
        bus.lcd_cs = 0;
        step(4);

        // Plain RAMWR from reset window
        addr_log.delete(); data_log.delete();
        wr_bus(0, 18'h2C);
        wr_bus(1, 18'h3FFFF); wr_bus(1, 18'h00001); wr_bus(1, 18'h15555);
        step(4);
        chk("t1_npix", 36'(addr_log.size()), 36'(3));
        for (int i = 0; i < 3 && i < addr_log.size(); i++) chk("t1_addr", 36'(addr_log[i]), 36'(i));
        if (data_log.size() == 3) begin
            chk("t1_data0", 36'(data_log[0]), 36'h3FFFF);
            chk("t1_data2", 36'(data_log[2]), 36'h15555);
        end
        chk("t1_overflow", 36'(overflow), 36'(0));

        // Window with wrap
        addr_log.delete();
        send_win(8'h2A, 10, 11);
        send_win(8'h2B, 5, 6);
        wr_bus(0, 18'h2C);
        for (int i = 0; i < 5; i++) wr_bus(1, 18'($urandom_range(0, 'h3FFFF)));
        step(4);
        chk("t2_npix", 36'(addr_log.size()), 36'(5));
        for (int i = 0; i < 5 && i < addr_log.size(); i++) chk("t2_addr", 36'(addr_log[i]), 36'(exp2[i]));

        // Stalled consumer overflows the FIFO
        px_ready = 0;
        wr_bus(0, 18'h2C);
        for (int i = 0; i < 6; i++) wr_bus(1, 18'($urandom_range(0, 'h3FFFF)));
        chk("t3_model_q", 36'(exp_q.size()), 36'(DEPTH));
        chk("t3_px_valid", 36'(px_valid), 36'(1));
        chk("t3_overflow", 36'(overflow), 36'(m_ovf));
        p0 = n_pop;
        px_ready = 1;
        step(12);
        chk("t3_pops", 36'(n_pop - p0), 36'(4));
        chk("t3_drained", 36'(px_valid), 36'(0));

        // Reads: ID bytes, status, and a write ignored while deselected
        wr_bus(0, 18'h04);
        rd_check("rd_id0", 18'h00);
        rd_check("rd_id1", 18'h93);
        rd_check("rd_id2", 18'h41);
        rd_check("rd_id3", 18'h00);
        wr_bus(0, 18'h0A);
        rd_check("rd_status", {15'd0, te_exp, m_ovf, exp_q.size() != 0});
        wr_bus(0, 18'h2C);
        p0 = n_pop;
        bus.lcd_cs = 1; step(4);
        wr_bus(1, 18'h2AAAA);
        bus.lcd_cs = 0; step(4);
        chk("cs_hi_nopix", 36'(n_pop - p0), 36'(0));

        // Tearing effect
        set_te(1);
        step(3 * FRAME + 20);
        chk("te_locked", 36'(locked), 36'(1));
        set_te(0);
        step(FRAME + 10);

        // Randomized windows and pixel bursts
        for (int w = 0; w < 6; w++) begin
            s = $urandom_range(0, WIDTH + 15); e = $urandom_range(0, WIDTH + 15);
            send_win(8'h2A, s, e);
            s = $urandom_range(0, HEIGHT + 15); e = $urandom_range(0, HEIGHT + 15);
            send_win(8'h2B, s, e);
            wr_bus(0, (w == 0 || $urandom_range(0, 1) == 0) ? 18'h2C : 18'h3C);
            n = $urandom_range(3, 12);
            for (int i = 0; i < n; i++) wr_bus(1, 18'($urandom_range(0, 'h3FFFF)));
        end
        step(4);
        chk("rand_drained", 36'(exp_q.size()), 36'(0));

        // Panel reset in the middle of a RAMWR
        px_ready = 0;
        wr_bus(0, 18'h2C);
        wr_bus(1, 18'h01234); wr_bus(1, 18'h05678);
        chk("mid_px_valid", 36'(px_valid), 36'(1));
        px_check = 0;
        lcd_rst = 0;
        step(4);
        chk("mid_flushed", 36'(px_valid), 36'(0));
        chk("mid_overflow", 36'(overflow), 36'(0));
        model_reset();
        lcd_rst = 1;
        step(4);
        px_check = 1;
        px_ready = 1;
        p0 = n_pop;
        for (int i = 0; i < 3; i++) wr_bus(1, 18'($urandom_range(0, 'h3FFFF)));
        step(4);
        chk("mid_nopix", 36'(n_pop - p0), 36'(0));
        rd_check("mid_rd_cmd0", 18'h0);
        addr_log.delete();
        wr_bus(0, 18'h2C);
        wr_bus(1, 18'h00777);
        step(4);
        chk("mid_new_npix", 36'(addr_log.size()), 36'(1));
        if (addr_log.size() == 1) chk("mid_new_addr", 36'(addr_log[0]), 36'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
